reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  Circular in-order reorder buffer. Allocates ROB tags to decoded instructions (these tags drive regfile
//  id_rn_*), accepts out-of-order completion results from the CDB and retires the head in program order.
//  Retirement drives regfile rob_wr_*. Tag 0 (`ZERO_ROB_IDX) is reserved to mean "value ready, no producer",
//  so live tags are 1..ROB_SIZE-1.
// PARAMETERS
//  ROB_SIZE  (1<<`ROB_IDX_LN)  tag space; capacity = ROB_SIZE-1 entries
//  ROB_BIT   `ROB_IDX_LN       tag width
// PORTS
//  clk           in   1          clock; all state updates on posedge
//  rst           in   1          synchronous, active-high reset
//  rsy           in   1          global ready; low => full hold, no state change, rob_wr_ena=0
//  rob_rb        in   1          rollback/flush (mispredict)
//  id_alloc_ena  in   1          ID requests one entry this cycle
//  id_alloc_wb   in   1          allocated instr writes a register
//  id_alloc_rd   in   REG_IDX    destination register
//  id_alloc_idx  out  ROB_IDX    tag granted = tail pointer (combinational)
//  rob_full      out  1          no free entry; ID must not allocate
//  rob_empty     out  1          no live entry
//  id_qry_idx1   in   ROB_IDX    operand-1 producer tag (from regfile id_src1)
//  id_qry_idx2   in   ROB_IDX    operand-2 producer tag
//  id_qry_rdy1   out  1          operand-1 value available
//  id_qry_rdy2   out  1          operand-2 value available
//  id_qry_val1   out  WORD       operand-1 value
//  id_qry_val2   out  WORD       operand-2 value
//  cdb_ena       in   1          completion broadcast valid
//  cdb_idx       in   ROB_IDX    completing tag
//  cdb_val       in   WORD       result
//  rob_wr_ena    out  1          retire write to regfile this cycle
//  rob_wr_rd     out  REG_IDX    retire destination
//  rob_wr_val    out  WORD       retire value
//  rob_wr_idx    out  ROB_IDX    retiring tag
// BEHAVIOUR
//  - Per-entry state: busy, ready, wb, rd, val. Also head, tail (1..ROB_SIZE-1) and count (0..ROB_SIZE-1).
//  - Reset: all busy/ready=0; head=tail=1; count=0. Outputs: rob_full=0, rob_empty=1, id_alloc_idx=1,
//    rob_wr_ena=0, id_qry_rdy*=1 only for tag 0.
//  - Pointer increment: ROB_SIZE-1 wraps to 1; tag 0 is never issued.
//  - rob_full = (count==ROB_SIZE-1); rob_empty = (count==0). Both come from registered count.
//  - Allocation is accepted iff id_alloc_ena && !rob_full && rsy && !rob_rb.
//    - Entry[tail] <= busy=1, ready=0, wb, rd; tail advances.
//    - id_alloc_ena while full is ignored. A same-cycle retire does not free a slot for it.
//  - Completion: cdb_ena && busy[cdb_idx] => ready=1, val=cdb_val. A CDB to a non-busy tag or tag 0 is ignored.
//  - Retire is combinational from the head: retire = rsy && !rob_rb && busy[head] && ready[head].
//    - rob_wr_ena = retire && wb[head]. rob_wr_rd/val/idx are taken from the head.
//    - At posedge on retire: busy[head]=0, head advances.
//    - Entries with wb=0 retire silently (rob_wr_ena=0), one entry per cycle.
//  - Latency: CDB at cycle N to the head tag => rob_wr_ena at cycle N+1. There is no same-cycle CDB-to-retire bypass.
//  - Query: rdy = (idx==0) || (busy[idx]&&ready[idx]) || (cdb_ena&&cdb_idx==idx).
//    - val = CDB value if CDB matches, else val[idx]; 0 for idx 0.
//  - Count: +1 on alloc, -1 on retire; unchanged if both happen in the same cycle.
//  - rob_rb has priority over everything: all busy=0, head=tail=1, count=0, rob_wr_ena=0 in that cycle.
//    CDB/alloc in the same cycle are dropped.
//  - rst has priority over rob_rb. Reset mid-operation discards all entries identically.
// STRUCTURE
//  - Shared macros in utils.v: `ROB_IDX_LN, `ROB_IDX_TP, `ZERO_ROB_IDX, `REG_IDX_TP, `WORD_TP, `ZERO_WORD.
//    Add there: `ROB_SIZE, `ROB_FIRST_IDX (=1).
//  - Single module, no sub-module. Tag wrap is a local function next_idx().
//  - Integration: id_rn_ena = id_alloc_ena&&id_alloc_wb&&!rob_full; id_rn_idx = id_alloc_idx;
//    rob_rb drives regfile reg_rb.
// TESTING
//  1. Reset, then alloc 3 (rd=5,6,7) -> tags 1,2,3. CDB tag2=0xAA, tag1=0x11 -> wr (5,0x11) then (6,0xAA) next cycle.
//  2. Alloc 15 entries -> rob_full=1 after the 15th. 16th ignored. Retire one -> next alloc gets tag 1 (wrap skips 0).
//  3. Full plus simultaneous retire and alloc_ena -> alloc rejected, count=14.
//  4. Query tag 4 while CDB tag4=0x1234 in the same cycle -> rdy=1, val=0x1234. Query tag 0 -> rdy=1.
//  5. Alloc with wb=0 at head, then CDB -> head advances, rob_wr_ena stays 0.
//  6. rob_rb with 5 live entries, CDB and alloc in the same cycle -> next cycle empty=1, id_alloc_idx=1, no write.
//     Repeat with rsy=0 -> state frozen.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// ---------------------------------------------------------------------------
// reorder_buffer_pkg
// Shared widths, tag constants and the per-entry payload type for the
// reorder buffer.
//   ROB_IDX_LN    : tag width; tag space is ROB_SIZE = 1 << ROB_IDX_LN
//   ZERO_ROB_IDX  : reserved tag meaning "value ready, no producer"
//   ROB_FIRST_IDX : first live tag; pointers wrap back here, never to 0
//   REG_IDX_LN    : architectural register index width
//   WORD_LN       : data word width
// ---------------------------------------------------------------------------
package reorder_buffer_pkg;

    localparam int ROB_IDX_LN    = 4;
    localparam int ROB_SIZE      = 1 << ROB_IDX_LN;
    localparam int ZERO_ROB_IDX  = 0;
    localparam int ROB_FIRST_IDX = 1;
    localparam int REG_IDX_LN    = 5;
    localparam int WORD_LN       = 32;

    // Payload carried by each entry; busy/ready live in separate vectors so
    // that flush can clear them in a single step.
    typedef struct packed {
        logic                  wb;
        logic [REG_IDX_LN-1:0] rd;
        logic [WORD_LN-1:0]    val;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
// Circular in-order reorder buffer. Hands out tags to decoded instructions,
// collects out-of-order results from the CDB and retires the head in program
// order. Tag 0 is reserved, so live tags are 1..ROB_SIZE-1.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   rsy                          global ready; low freezes all state
//   rob_rb                       rollback/flush
//   id_alloc_ena/wb/rd           allocation request from decode
//   id_alloc_idx                 tag granted (current tail)
//   rob_full, rob_empty          occupancy flags from registered count
//   id_qry_idx1/2                operand producer tags
//   id_qry_rdy1/2, id_qry_val1/2 operand availability and value
//   cdb_ena/idx/val              completion broadcast
//   rob_wr_ena/rd/val/idx        retirement write to the register file
// ---------------------------------------------------------------------------
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rsy,
    input  logic                  rob_rb,
    input  logic                  id_alloc_ena,
    input  logic                  id_alloc_wb,
    input  logic [REG_IDX_LN-1:0] id_alloc_rd,
    output logic [ROB_IDX_LN-1:0] id_alloc_idx,
    output logic                  rob_full,
    output logic                  rob_empty,
    input  logic [ROB_IDX_LN-1:0] id_qry_idx1,
    input  logic [ROB_IDX_LN-1:0] id_qry_idx2,
    output logic                  id_qry_rdy1,
    output logic                  id_qry_rdy2,
    output logic [WORD_LN-1:0]    id_qry_val1,
    output logic [WORD_LN-1:0]    id_qry_val2,
    input  logic                  cdb_ena,
    input  logic [ROB_IDX_LN-1:0] cdb_idx,
    input  logic [WORD_LN-1:0]    cdb_val,
    output logic                  rob_wr_ena,
    output logic [REG_IDX_LN-1:0] rob_wr_rd,
    output logic [WORD_LN-1:0]    rob_wr_val,
    output logic [ROB_IDX_LN-1:0] rob_wr_idx
);

    typedef logic [ROB_IDX_LN-1:0] rob_idx_t;

    localparam rob_idx_t LAST_IDX  = rob_idx_t'(ROB_SIZE - 1);
    localparam rob_idx_t FIRST_IDX = rob_idx_t'(ROB_FIRST_IDX);
    localparam rob_idx_t ZERO_IDX  = rob_idx_t'(ZERO_ROB_IDX);

    logic [ROB_SIZE-1:0] busy_q, busy_d;
    logic [ROB_SIZE-1:0] ready_q, ready_d;
    rob_entry_t          entry_q [ROB_SIZE];
    rob_entry_t          entry_d [ROB_SIZE];
    rob_idx_t            head_q, head_d;
    rob_idx_t            tail_q, tail_d;
    rob_idx_t            count_q, count_d;

    logic alloc;
    logic retire;

    // Pointer advance skips the reserved tag 0.
    function automatic rob_idx_t next_idx(input rob_idx_t idx);
        if (idx == LAST_IDX) begin
            return FIRST_IDX;
        end
        return idx + rob_idx_t'(1);
    endfunction

    // Tag 0 and a matching broadcast are ready immediately; otherwise the
    // entry must be busy and already completed.
    function automatic logic [WORD_LN:0] query(input rob_idx_t idx);
        if (idx == ZERO_IDX) begin
            return {1'b1, {WORD_LN{1'b0}}};
        end
        if (cdb_ena && cdb_idx == idx) begin
            return {1'b1, cdb_val};
        end
        return {busy_q[idx] && ready_q[idx], entry_q[idx].val};
    endfunction

    // Occupancy flags and the handshake terms. Both allocation and retire
    // are blocked by a stall or a flush; retire only looks at registered
    // ready, so a same-cycle broadcast to the head retires one cycle later.
    always_comb begin
        rob_full     = (count_q == LAST_IDX);
        rob_empty    = (count_q == ZERO_IDX);
        id_alloc_idx = tail_q;
        alloc        = id_alloc_ena && !rob_full && rsy && !rob_rb;
        retire       = rsy && !rob_rb && busy_q[head_q] && ready_q[head_q];
        rob_wr_ena   = retire && entry_q[head_q].wb;
        rob_wr_rd    = entry_q[head_q].rd;
        rob_wr_val   = entry_q[head_q].val;
        rob_wr_idx   = head_q;
        {id_qry_rdy1, id_qry_val1} = query(id_qry_idx1);
        {id_qry_rdy2, id_qry_val2} = query(id_qry_idx2);
    end

    // Next-state: flush wipes everything; otherwise apply completion, then
    // retire at the head, then allocation at the tail. Allocation never
    // lands on the head slot while it is live because full blocks it.
    always_comb begin
        busy_d  = busy_q;
        ready_d = ready_q;
        entry_d = entry_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rsy) begin
            if (rob_rb) begin
                busy_d  = '0;
                ready_d = '0;
                head_d  = FIRST_IDX;
                tail_d  = FIRST_IDX;
                count_d = ZERO_IDX;
            end else begin
                if (cdb_ena && cdb_idx != ZERO_IDX && busy_q[cdb_idx]) begin
                    ready_d[cdb_idx]     = 1'b1;
                    entry_d[cdb_idx].val = cdb_val;
                end
                if (retire) begin
                    busy_d[head_q]  = 1'b0;
                    ready_d[head_q] = 1'b0;
                    head_d          = next_idx(head_q);
                end
                if (alloc) begin
                    busy_d[tail_q]     = 1'b1;
                    ready_d[tail_q]    = 1'b0;
                    entry_d[tail_q].wb = id_alloc_wb;
                    entry_d[tail_q].rd = id_alloc_rd;
                    tail_d             = next_idx(tail_q);
                end
                if (alloc && !retire) begin
                    count_d = count_q + rob_idx_t'(1);
                end else if (retire && !alloc) begin
                    count_d = count_q - rob_idx_t'(1);
                end
            end
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            ready_q <= '0;
            head_q  <= FIRST_IDX;
            tail_q  <= FIRST_IDX;
            count_q <= ZERO_IDX;
        end else begin
            busy_q  <= busy_d;
            ready_q <= ready_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload is only ever read behind busy/ready, so it needs no reset.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tb_reorder_buffer
// Self-checking bench for reorder_buffer. A program-order queue of live
// instructions models the buffer; every cycle the outputs are compared
// against it, and directed scenarios add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst, rsy, rob_rb;
    logic        id_alloc_ena, id_alloc_wb;
    logic [4:0]  id_alloc_rd;
    logic [3:0]  id_alloc_idx;
    logic        rob_full, rob_empty;
    logic [3:0]  id_qry_idx1, id_qry_idx2;
    logic        id_qry_rdy1, id_qry_rdy2;
    logic [31:0] id_qry_val1, id_qry_val2;
    logic        cdb_ena;
    logic [3:0]  cdb_idx;
    logic [31:0] cdb_val;
    logic        rob_wr_ena;
    logic [4:0]  rob_wr_rd;
    logic [31:0] rob_wr_val;
    logic [3:0]  rob_wr_idx;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          tag;
        bit          wb;
        int          rd;
        bit          rdy;
        logic [31:0] val;
    } ent_t;

    ent_t modelQ[$];
    int   modelTail = 1;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rsy(rsy), .rob_rb(rob_rb),
        .id_alloc_ena(id_alloc_ena), .id_alloc_wb(id_alloc_wb),
        .id_alloc_rd(id_alloc_rd), .id_alloc_idx(id_alloc_idx),
        .rob_full(rob_full), .rob_empty(rob_empty),
        .id_qry_idx1(id_qry_idx1), .id_qry_idx2(id_qry_idx2),
        .id_qry_rdy1(id_qry_rdy1), .id_qry_rdy2(id_qry_rdy2),
        .id_qry_val1(id_qry_val1), .id_qry_val2(id_qry_val2),
        .cdb_ena(cdb_ena), .cdb_idx(cdb_idx), .cdb_val(cdb_val),
        .rob_wr_ena(rob_wr_ena), .rob_wr_rd(rob_wr_rd),
        .rob_wr_val(rob_wr_val), .rob_wr_idx(rob_wr_idx)
    );

    always #5 clk = ~clk;

    // Tags cycle 1..15 and never hand out 0.
    function automatic int wrapNext(input int t);
        return (t % 15) + 1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Operand availability from the live-instruction list.
    task automatic modelQuery(input int idx, output bit rdy, output logic [31:0] val);
        rdy = 1'b0;
        val = '0;
        if (idx == 0) begin
            rdy = 1'b1;
        end else if (cdb_ena && int'(cdb_idx) == idx) begin
            rdy = 1'b1;
            val = cdb_val;
        end else begin
            foreach (modelQ[i]) begin
                if (modelQ[i].tag == idx) begin
                    rdy = modelQ[i].rdy;
                    val = modelQ[i].val;
                end
            end
        end
    endtask

    // Compare every observable output against the model.
    task automatic compareAll();
        bit          retire, rdy;
        logic [31:0] val;
        retire = rsy && !rob_rb && modelQ.size() > 0 && modelQ[0].rdy;
        checkOutput("model_full", rob_full, modelQ.size() == 15);
        checkOutput("model_empty", rob_empty, modelQ.size() == 0);
        checkOutput("model_alloc_idx", id_alloc_idx, modelTail);
        checkOutput("model_wr_ena", rob_wr_ena, retire && modelQ[0].wb);
        if (retire && modelQ[0].wb) begin
            checkOutput("model_wr_rd", rob_wr_rd, modelQ[0].rd);
            checkOutput("model_wr_val", rob_wr_val, modelQ[0].val);
            checkOutput("model_wr_idx", rob_wr_idx, modelQ[0].tag);
        end
        modelQuery(int'(id_qry_idx1), rdy, val);
        checkOutput("model_qry_rdy1", id_qry_rdy1, rdy);
        if (rdy) checkOutput("model_qry_val1", id_qry_val1, val);
        modelQuery(int'(id_qry_idx2), rdy, val);
        checkOutput("model_qry_rdy2", id_qry_rdy2, rdy);
        if (rdy) checkOutput("model_qry_val2", id_qry_val2, val);
    endtask

    // Advance the model with the inputs present at the clock edge.
    task automatic updateModel();
        bit retire, doAlloc;
        if (rst) begin
            modelQ.delete();
            modelTail = 1;
        end else if (rsy) begin
            if (rob_rb) begin
                modelQ.delete();
                modelTail = 1;
            end else begin
                retire  = modelQ.size() > 0 && modelQ[0].rdy;
                doAlloc = id_alloc_ena && modelQ.size() < 15;
                if (cdb_ena) begin
                    foreach (modelQ[i]) begin
                        if (modelQ[i].tag == int'(cdb_idx)) begin
                            modelQ[i].rdy = 1'b1;
                            modelQ[i].val = cdb_val;
                        end
                    end
                end
                if (retire) void'(modelQ.pop_front());
                if (doAlloc) begin
                    modelQ.push_back('{tag: modelTail, wb: id_alloc_wb, rd: int'(id_alloc_rd), rdy: 1'b0, val: '0});
                    modelTail = wrapNext(modelTail);
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic ae, input logic wb, input logic [4:0] rd,
                                 input logic ce, input logic [3:0] ci, input logic [31:0] cv,
                                 input logic [3:0] q1, input logic [3:0] q2,
                                 input logic rs, input logic rb);
        id_alloc_ena = ae;
        id_alloc_wb  = wb;
        id_alloc_rd  = rd;
        cdb_ena      = ce;
        cdb_idx      = ci;
        cdb_val      = cv;
        id_qry_idx1  = q1;
        id_qry_idx2  = q2;
        rsy          = rs;
        rob_rb       = rb;
        @(negedge clk);
        compareAll();
    endtask

    task automatic finishCycle();
        @(posedge clk);
        updateModel();
        #1;
    endtask

    task automatic cycle(input logic ae, input logic wb, input logic [4:0] rd,
                         input logic ce, input logic [3:0] ci, input logic [31:0] cv);
        applyStimulus(ae, wb, rd, ce, ci, cv, 4'd0, 4'd0, 1'b1, 1'b0);
        finishCycle();
    endtask

    task automatic resetCycle();
        rst = 1'b1;
        cycle(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rsy = 1'b1;
        rob_rb = 1'b0;
        id_alloc_ena = 1'b0;
        id_alloc_wb = 1'b0;
        id_alloc_rd = '0;
        cdb_ena = 1'b0;
        cdb_idx = '0;
        cdb_val = '0;
        id_qry_idx1 = '0;
        id_qry_idx2 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        modelQ.delete();
        modelTail = 1;

        // Reset state and in-order retire of out-of-order completions.
        applyStimulus(1'b1, 1'b1, 5'd5, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        checkOutput("reset_empty", rob_empty, 1);
        checkOutput("reset_full", rob_full, 0);
        checkOutput("reset_alloc_idx", id_alloc_idx, 1);
        checkOutput("reset_wr_ena", rob_wr_ena, 0);
        checkOutput("reset_qry0_rdy", id_qry_rdy1, 1);
        finishCycle();
        applyStimulus(1'b1, 1'b1, 5'd6, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        checkOutput("alloc_tag2", id_alloc_idx, 2);
        finishCycle();
        applyStimulus(1'b1, 1'b1, 5'd7, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        checkOutput("alloc_tag3", id_alloc_idx, 3);
        finishCycle();
        cycle(1'b0, 1'b0, 5'd0, 1'b1, 4'd2, 32'hAA);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 4'd1, 32'h11, 4'd0, 4'd0, 1'b1, 1'b0);
        checkOutput("no_bypass_wr_ena", rob_wr_ena, 0);
        finishCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        checkOutput("retire1_ena", rob_wr_ena, 1);
        checkOutput("retire1_rd", rob_wr_rd, 5);
        checkOutput("retire1_val", rob_wr_val, 32'h11);
        checkOutput("retire1_idx", rob_wr_idx, 1);
        finishCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        checkOutput("retire2_rd", rob_wr_rd, 6);
        checkOutput("retire2_val", rob_wr_val, 32'hAA);
        finishCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        checkOutput("head3_not_ready", rob_wr_ena, 0);
        finishCycle();
        cycle(1'b0, 1'b0, 5'd0, 1'b1, 4'd3, 32'h33);
        cycle(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 32'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        checkOutput("drained_empty", rob_empty, 1);
        finishCycle();

        // Fill to capacity, wrap past tag 0, full with simultaneous retire.
        resetCycle();
        for (int i = 0; i < 15; i++) cycle(1'b1, 1'b1, 5'(i + 1), 1'b0, 4'd0, 32'd0);
        applyStimulus(1'b1, 1'b1, 5'd16, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        checkOutput("fill_full", rob_full, 1);
        checkOutput("fill_tail_wraps", id_alloc_idx, 1);
        finishCycle();
        cycle(1'b1, 1'b1, 5'd17, 1'b1, 4'd1, 32'h100);
        applyStimulus(1'b1, 1'b1, 5'd18, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        checkOutput("full_retire_ena", rob_wr_ena, 1);
        checkOutput("full_retire_val", rob_wr_val, 32'h100);
        finishCycle();
        applyStimulus(1'b1, 1'b1, 5'd20, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        checkOutput("after_retire_not_full", rob_full, 0);
        checkOutput("wrap_gets_tag1", id_alloc_idx, 1);
        finishCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        checkOutput("refill_full", rob_full, 1);
        finishCycle();

        // Query with same-cycle broadcast, stored value, and an unready tag.
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 4'd4, 32'h1234, 4'd4, 4'd0, 1'b1, 1'b0);
        checkOutput("qry_bypass_rdy", id_qry_rdy1, 1);
        checkOutput("qry_bypass_val", id_qry_val1, 32'h1234);
        checkOutput("qry_zero_rdy", id_qry_rdy2, 1);
        checkOutput("qry_zero_val", id_qry_val2, 0);
        finishCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 4'd4, 4'd5, 1'b1, 1'b0);
        checkOutput("qry_stored_val", id_qry_val1, 32'h1234);
        checkOutput("qry_unready", id_qry_rdy2, 0);
        finishCycle();

        // Silent retire of a non-writing instruction.
        resetCycle();
        cycle(1'b1, 1'b0, 5'd9, 1'b0, 4'd0, 32'd0);
        cycle(1'b0, 1'b0, 5'd0, 1'b1, 4'd1, 32'h55);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        checkOutput("silent_no_write", rob_wr_ena, 0);
        finishCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        checkOutput("silent_retired_empty", rob_empty, 1);
        checkOutput("silent_tail", id_alloc_idx, 2);
        finishCycle();

        // Rollback drops everything including same-cycle CDB and alloc.
        resetCycle();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 5'(i + 1), 1'b0, 4'd0, 32'd0);
        cycle(1'b0, 1'b0, 5'd0, 1'b1, 4'd1, 32'h77);
        applyStimulus(1'b1, 1'b1, 5'd8, 1'b1, 4'd2, 32'h22, 4'd0, 4'd0, 1'b1, 1'b1);
        checkOutput("rb_no_write", rob_wr_ena, 0);
        finishCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        checkOutput("rb_empty", rob_empty, 1);
        checkOutput("rb_tail", id_alloc_idx, 1);
        checkOutput("rb_after_wr", rob_wr_ena, 0);
        finishCycle();

        // Stall freezes state even with rollback, CDB and alloc asserted.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 5'(i + 10), 1'b0, 4'd0, 32'd0);
        cycle(1'b0, 1'b0, 5'd0, 1'b1, 4'd1, 32'h88);
        applyStimulus(1'b1, 1'b1, 5'd13, 1'b1, 4'd2, 32'h99, 4'd0, 4'd0, 1'b0, 1'b1);
        checkOutput("stall_no_write", rob_wr_ena, 0);
        finishCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 4'd2, 4'd0, 1'b1, 1'b0);
        checkOutput("stall_kept_wr", rob_wr_ena, 1);
        checkOutput("stall_kept_rd", rob_wr_rd, 10);
        checkOutput("stall_kept_tail", id_alloc_idx, 4);
        checkOutput("stall_cdb_dropped", id_qry_rdy1, 0);
        finishCycle();

        // Mixed traffic checked against the model only.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom),
                          1'($urandom_range(0, 2) != 0), 4'($urandom), $urandom,
                          4'($urandom), 4'($urandom),
                          1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 39) == 0));
            finishCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
